keypad_scan_ctrl: RTL and testbench

//  Drives the 3 column lines of the 4x3 membrane keypad, samples the 4 row lines and debounces them.

---
 rtl/keypad_pkg.sv | 31 +++
 rtl/keypad_decode.sv | 26 ++
 rtl/keypad_scan_ctrl.sv | 167 ++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad scanner and its consumers.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } kp_state_t;

  typedef enum logic [1:0] {
    CLS_NONE   = 2'd0,
    CLS_SINGLE = 2'd1,
    CLS_MULTI  = 2'd2
  } kp_class_t;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;
  localparam logic [3:0] KEY_NONE = 4'hF;
  localparam logic [2:0] COL_IDLE = 3'b111;

  // Matrix index r*3+c -> printed key value
  function automatic logic [3:0] idx_to_code(input int idx);
    logic [3:0] c;
    if (idx < 9)        c = 4'(idx + 1);
    else if (idx == 9)  c = KEY_STAR;
    else if (idx == 10) c = 4'd0;
    else                c = KEY_HASH;
    return c;
  endfunction

endpackage

// File: rtl/keypad_decode.sv
// Classifies a 12-bit pressed-key snapshot and reports the code of its lowest set key.
module keypad_decode
  import keypad_pkg::*;
(
  input  logic [11:0] snap,
  output kp_class_t   cls,
  output logic [3:0]  code
);

  // Population count plus lowest-index key; code is only meaningful for SINGLE
  always_comb begin
    int n;
    n    = 0;
    code = KEY_NONE;
    for (int i = 11; i >= 0; i--) begin
      if (snap[i]) begin
        n    = n + 1;
        code = idx_to_code(i);
      end
    end
    if (n == 0)      cls = CLS_NONE;
    else if (n == 1) cls = CLS_SINGLE;
    else             cls = CLS_MULTI;
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Column scanner, row synchroniser and press/release debouncer for a 4x3 keypad.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_TICKS     = 100000,
  parameter int DEBOUNCE_SCANS = 20,
  parameter int RELEASE_SCANS  = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] row,
  output logic [2:0] col,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam int SW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam int RW = $clog2(RELEASE_SCANS + 1);

  logic [3:0]    row_s1, row_s2;
  logic [SW-1:0] slot;
  logic [11:0]   snap, snap_nxt;
  logic          slot_last, scan_done;
  kp_class_t     cls;
  logic [3:0]    code;

  kp_state_t     st, st_n;
  logic [3:0]    cand, cand_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [RW-1:0] rel, rel_n, rel_inc;
  logic          valid_n, held_n;
  logic [3:0]    code_n;

  assign slot_last = (slot == SW'(SCAN_TICKS - 1));
  assign scan_done = enable && (col == 3'b011) && slot_last;

  // Merge the current column's synced rows into the snapshot (rows are active-low)
  always_comb begin
    int c;
    snap_nxt = snap;
    case (col)
      3'b101:  c = 1;
      3'b011:  c = 2;
      default: c = 0;
    endcase
    for (int r = 0; r < 4; r++) snap_nxt[r*3 + c] = ~row_s2[r];
  end

  // Decoder sees the completed snapshot in the same cycle the last column is sampled
  keypad_decode u_dec (
    .snap (snap_nxt),
    .cls  (cls),
    .code (code)
  );

  // Synchroniser, slot counter, column rotation and snapshot capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_s1 <= 4'hF;
      row_s2 <= 4'hF;
      col    <= 3'b110;
      slot   <= '0;
      snap   <= '0;
    end else begin
      row_s1 <= row;
      row_s2 <= row_s1;
      if (!enable) begin
        col  <= COL_IDLE;
        slot <= '0;
        snap <= '0;
      end else if (col == COL_IDLE) begin
        col  <= 3'b110;
        slot <= '0;
      end else if (slot_last) begin
        slot <= '0;
        snap <= snap_nxt;
        col  <= {col[1:0], col[2]};
      end else begin
        slot <= slot + 1'b1;
      end
    end
  end

  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
  assign rel_inc = (rel == '1) ? rel : rel + 1'b1;

  // Debounce FSM next-state and output logic; evaluated once per full scan
  always_comb begin
    st_n    = st;
    cand_n  = cand;
    cnt_n   = cnt;
    rel_n   = rel;
    valid_n = 1'b0;
    code_n  = key_code;
    held_n  = key_held;
    if (!enable) begin
      st_n   = ST_IDLE;
      cnt_n  = '0;
      rel_n  = '0;
      held_n = 1'b0;
    end else if (scan_done) begin
      case (st)
        ST_IDLE: begin
          if (cls == CLS_SINGLE) begin
            st_n   = ST_DEBOUNCE;
            cand_n = code;
            cnt_n  = CW'(1);
          end
        end
        ST_DEBOUNCE: begin
          if (cls == CLS_SINGLE && code == cand) begin
            cnt_n = cnt_inc;
            if (cnt_inc >= CW'(DEBOUNCE_SCANS)) begin
              st_n    = ST_HELD;
              valid_n = 1'b1;
              code_n  = cand;
              held_n  = 1'b1;
              rel_n   = '0;
            end
          end else begin
            st_n  = ST_IDLE;
            cnt_n = '0;
          end
        end
        ST_HELD: begin
          if (cls == CLS_NONE) begin
            rel_n = rel_inc;
            if (rel_inc >= RW'(RELEASE_SCANS)) begin
              st_n   = ST_IDLE;
              held_n = 1'b0;
              rel_n  = '0;
              cnt_n  = '0;
            end
          end else begin
            rel_n = '0;
          end
        end
        default: st_n = ST_IDLE;
      endcase
    end
  end

  // FSM state and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st        <= ST_IDLE;
      cand      <= KEY_NONE;
      cnt       <= '0;
      rel       <= '0;
      key_valid <= 1'b0;
      key_code  <= KEY_NONE;
      key_held  <= 1'b0;
    end else begin
      st        <= st_n;
      cand      <= cand_n;
      cnt       <= cnt_n;
      rel       <= rel_n;
      key_valid <= valid_n;
      key_code  <= code_n;
      key_held  <= held_n;
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a behavioural keypad matrix.
module tb_keypad_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b1;
  logic [3:0]  row;
  logic [2:0]  col;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_held;
  logic [11:0] keys = '0;
  int          n_assert = 0;
  int          n_fail = 0;
  int          vcount = 0;

  keypad_scan_ctrl #(.SCAN_TICKS(4), .DEBOUNCE_SCANS(3), .RELEASE_SCANS(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .row       (row),
    .col       (col),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Pressed keys pull their row low only while their column is driven
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      row[r] = ~((keys[r*3]   && col == 3'b110) ||
                 (keys[r*3+1] && col == 3'b101) ||
                 (keys[r*3+2] && col == 3'b011));
  end

  // Count every accepted-key pulse
  always @(posedge clk) if (key_valid === 1'b1) vcount <= vcount + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Leave the caller at the negedge just after a full-scan boundary (col 011 -> 110)
  task automatic align_scan();
    int n = 0;
    while (col !== 3'b011 && n < 64) begin @(negedge clk); n++; end
    while (col !== 3'b110 && n < 64) begin @(negedge clk); n++; end
    chk("align_in_budget", 32'(n < 64), 32'd1);
  endtask

  // Key pressed just after a boundary: pulse appears after the 3rd complete scan
  task automatic expect_accept(input logic [3:0] c);
    repeat (35) @(negedge clk);
    chk("valid_not_early", 32'(key_valid), 32'd0);
    @(negedge clk);
    chk("valid_pulse", 32'(key_valid), 32'd1);
    chk("code_on_accept", 32'(key_code), 32'(c));
    chk("held_on_accept", 32'(key_held), 32'd1);
    @(negedge clk);
    chk("valid_one_cycle", 32'(key_valid), 32'd0);
  endtask

  initial begin
    logic [2:0] pat [3];
    int v0;
    pat[0] = 3'b110; pat[1] = 3'b101; pat[2] = 3'b011;

    // Reset values
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_col", 32'(col), 32'h6);
    chk("rst_valid", 32'(key_valid), 32'd0);
    chk("rst_code", 32'(key_code), 32'hF);
    chk("rst_held", 32'(key_held), 32'd0);

    // 1: idle scan pattern, four cycles per column
    reset = 1'b0;
    for (int i = 0; i < 24; i++) begin
      chk("col_seq", 32'(col), 32'(pat[(i / 4) % 3]));
      @(negedge clk);
    end
    repeat (40) @(negedge clk);
    chk("t1_no_valid", 32'(vcount), 32'd0);
    chk("t1_code", 32'(key_code), 32'hF);

    // 2: '5' (row1, col1) held, then released
    align_scan();
    keys[4] = 1'b1;
    expect_accept(4'd5);
    keys = '0;
    align_scan();
    chk("t2_held_1scan", 32'(key_held), 32'd1);
    align_scan();
    chk("t2_released", 32'(key_held), 32'd0);
    chk("t2_one_pulse", 32'(vcount), 32'd1);

    // 3: '#' for only two scans
    align_scan();
    keys[11] = 1'b1;
    align_scan();
    align_scan();
    keys = '0;
    repeat (4) align_scan();
    chk("t3_no_valid", 32'(vcount), 32'd1);
    chk("t3_code_kept", 32'(key_code), 32'd5);
    chk("t3_not_held", 32'(key_held), 32'd0);

    // 4: '1'+'2' ghosting, then '2' released
    align_scan();
    keys[0] = 1'b1; keys[1] = 1'b1;
    repeat (10) align_scan();
    chk("t4_multi_ignored", 32'(vcount), 32'd1);
    keys[1] = 1'b0;
    expect_accept(4'd1);
    keys = '0;
    repeat (3) align_scan();
    chk("t4_released", 32'(key_held), 32'd0);

    // 5: '0' (row3, col1) held long, brief dropout
    align_scan();
    keys[10] = 1'b1;
    expect_accept(4'd0);
    v0 = vcount;
    repeat (10) align_scan();
    chk("t5_no_repeat", 32'(vcount - v0), 32'd0);
    chk("t5_held", 32'(key_held), 32'd1);
    keys = '0;
    align_scan();
    keys[10] = 1'b1;
    repeat (3) align_scan();
    chk("t5_still_held", 32'(key_held), 32'd1);
    chk("t5_no_new_pulse", 32'(vcount - v0), 32'd0);
    keys = '0;
    repeat (3) align_scan();
    chk("t5_released", 32'(key_held), 32'd0);

    // 6a: reset during debounce of '7'
    align_scan();
    keys[6] = 1'b1;
    align_scan();
    align_scan();
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_col", 32'(col), 32'h6);
    chk("t6_rst_code", 32'(key_code), 32'hF);
    chk("t6_rst_held", 32'(key_held), 32'd0);
    keys = '0;
    reset = 1'b0;
    v0 = vcount;
    repeat (5) align_scan();
    chk("t6_no_spurious", 32'(vcount - v0), 32'd0);

    // 6b: enable dropped while '9' is held
    align_scan();
    keys[8] = 1'b1;
    expect_accept(4'd9);
    v0 = vcount;
    align_scan();
    enable = 1'b0;
    @(negedge clk);
    chk("t6_dis_col", 32'(col), 32'h7);
    chk("t6_dis_held", 32'(key_held), 32'd0);
    chk("t6_dis_code", 32'(key_code), 32'd9);
    repeat (50) @(negedge clk);
    chk("t6_dis_col_stays", 32'(col), 32'h7);
    chk("t6_dis_no_valid", 32'(vcount - v0), 32'd0);
    keys = '0;
    enable = 1'b1;
    @(negedge clk);
    chk("t6_en_col0", 32'(col), 32'h6);
    repeat (4) @(negedge clk);
    chk("t6_en_col1", 32'(col), 32'h5);
    repeat (5) align_scan();
    chk("t6_end_no_valid", 32'(vcount - v0), 32'd0);
    chk("t6_end_code", 32'(key_code), 32'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
